bc_arb_ctrl: RTL and testbench

BC_ARB_CTRL -- requirements
Module: bc_arb_ctrl

---
 rtl/bc_arb_ctrl_if.sv | 28 ++
 rtl/bc_arb_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bc_arb_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bc_arb_ctrl_if.sv
// bc_arb_ctrl_if: request / grant / select bundle between the bus requesters
// and the bc_arb_ctrl arbiter. The stall counter stays on the arbiter's
// plain ports so this bundle carries no width parameter.
interface bc_arb_ctrl_if;
  logic       dg_req;
  logic       ps_req;
  logic       rf_req;
  logic       dm_req;
  logic       imm_req;
  logic [1:0] bc_drr_sclt;
  logic [1:0] bc_di_sclt;
  logic [2:0] drr_gnt;
  logic [1:0] di_gnt;
  logic       out_vld;
  logic [2:0] out_src;

  // Requester side: raises requests, observes selects and grants.
  modport master (
    output dg_req, ps_req, rf_req, dm_req, imm_req,
    input  bc_drr_sclt, bc_di_sclt, drr_gnt, di_gnt, out_vld, out_src
  );

  // Arbiter side.
  modport slave (
    input  dg_req, ps_req, rf_req, dm_req, imm_req,
    output bc_drr_sclt, bc_di_sclt, drr_gnt, di_gnt, out_vld, out_src
  );
endinterface

// File: rtl/bc_arb_ctrl.sv
// bc_arb_ctrl: bus-path arbiter.
// The registered path (dg/ps/rf) is arbitrated combinationally; the winner's
// word is delivered on the bus output one cycle later. While no delivery is
// pending, the direct path (dm over imm) owns the bus output. A saturating
// counter tracks cycles in which some asserted request was left ungranted.
// Macro BC_RR_EN: round-robin registered-path arbitration (pointer resets to
// "last = rf"); undefined gives fixed priority dg > ps > rf with no pointer.
module bc_arb_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bc_arb_ctrl_if.slave     bus,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    SRC_DG   = 2'b00,
    SRC_PS   = 2'b01,
    SRC_RF   = 2'b10,
    SRC_NONE = 2'b11
  } drr_sel_e;

  typedef enum logic [1:0] {
    DI_DM   = 2'b00,
    DI_REG  = 2'b01,
    DI_IMM  = 2'b10,
    DI_NONE = 2'b11
  } di_sel_e;

  typedef enum logic [2:0] {
    TAG_NONE = 3'd0,
    TAG_DG   = 3'd1,
    TAG_PS   = 3'd2,
    TAG_RF   = 3'd3,
    TAG_DM   = 3'd4,
    TAG_IMM  = 3'd5
  } tag_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0] reg_req;
  logic [1:0] di_req;
  drr_sel_e   drr_sel;
  di_sel_e    di_sel;
  logic [2:0] drr_gnt;
  logic [1:0] di_gnt;
  tag_e       drr_tag;
  tag_e       out_tag;
  logic       pend;
  tag_e       pend_tag;
  logic       denied;

  assign reg_req = {bus.rf_req, bus.ps_req, bus.dg_req};
  assign di_req  = {bus.imm_req, bus.dm_req};

`ifdef BC_RR_EN
  drr_sel_e last;

  // Round-robin pick: search starts just after the last granted source.
  always_comb begin
    drr_sel = SRC_NONE;
    case (last)
      SRC_DG: begin
        if      (bus.ps_req) drr_sel = SRC_PS;
        else if (bus.rf_req) drr_sel = SRC_RF;
        else if (bus.dg_req) drr_sel = SRC_DG;
      end
      SRC_PS: begin
        if      (bus.rf_req) drr_sel = SRC_RF;
        else if (bus.dg_req) drr_sel = SRC_DG;
        else if (bus.ps_req) drr_sel = SRC_PS;
      end
      default: begin
        if      (bus.dg_req) drr_sel = SRC_DG;
        else if (bus.ps_req) drr_sel = SRC_PS;
        else if (bus.rf_req) drr_sel = SRC_RF;
      end
    endcase
  end

  // Pointer remembers the last winner; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= SRC_RF;
    end else if (drr_sel != SRC_NONE) begin
      last <= drr_sel;
    end
  end
`else
  // Fixed priority pick: dg > ps > rf.
  always_comb begin
    drr_sel = SRC_NONE;
    if      (bus.dg_req) drr_sel = SRC_DG;
    else if (bus.ps_req) drr_sel = SRC_PS;
    else if (bus.rf_req) drr_sel = SRC_RF;
  end
`endif

  // Decode the registered-path winner into its grant bit and source tag.
  always_comb begin
    drr_gnt = '0;
    drr_tag = TAG_NONE;
    case (drr_sel)
      SRC_DG: begin drr_gnt = 3'b001; drr_tag = TAG_DG; end
      SRC_PS: begin drr_gnt = 3'b010; drr_tag = TAG_PS; end
      SRC_RF: begin drr_gnt = 3'b100; drr_tag = TAG_RF; end
      default: ;
    endcase
  end

  // Bus output: a pending registered word pre-empts the direct path.
  always_comb begin
    di_sel  = DI_NONE;
    di_gnt  = '0;
    out_tag = TAG_NONE;
    if (pend) begin
      di_sel  = DI_REG;
      out_tag = pend_tag;
    end else if (bus.dm_req) begin
      di_sel  = DI_DM;
      di_gnt  = 2'b01;
      out_tag = TAG_DM;
    end else if (bus.imm_req) begin
      di_sel  = DI_IMM;
      di_gnt  = 2'b10;
      out_tag = TAG_IMM;
    end
  end

  assign denied = (|(reg_req & ~drr_gnt)) | (|(di_req & ~di_gnt));

  // Pipeline register: a grant this cycle becomes a delivery next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_tag <= TAG_NONE;
    end else begin
      pend <= |drr_gnt;
      if (|drr_gnt) begin
        pend_tag <= drr_tag;
      end
    end
  end

  // Saturating stall counter; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (denied && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign bus.bc_drr_sclt = drr_sel;
  assign bus.drr_gnt     = drr_gnt;
  assign bus.bc_di_sclt  = di_sel;
  assign bus.di_gnt      = di_gnt;
  assign bus.out_vld     = pend;
  assign bus.out_src     = out_tag;

endmodule

// File: tb/tb_bc_arb_ctrl.sv
// tb_bc_arb_ctrl: self-checking bench for bc_arb_ctrl. Two instances share
// the stimulus: CNT_W=8 and CNT_W=2 (the latter saturates quickly). Expected
// outputs come from a count/queue-level model of the arbitration rules.
// Honours BC_RR_EN the same way as the design.
`timescale 1ns/1ps
module tb_bc_arb_ctrl;

  localparam logic [4:0] R_DG  = 5'b00001;
  localparam logic [4:0] R_PS  = 5'b00010;
  localparam logic [4:0] R_RF  = 5'b00100;
  localparam logic [4:0] R_DM  = 5'b01000;
  localparam logic [4:0] R_IMM = 5'b10000;

  typedef struct packed {
    logic [1:0] drr_sclt;
    logic [2:0] drr_gnt;
    logic [1:0] di_sclt;
    logic [1:0] di_gnt;
    logic       out_vld;
    logic [2:0] out_src;
    logic [7:0] stall;
    logic [1:0] stall_s;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dg_req, ps_req, rf_req, dm_req, imm_req, stall_clr;
  logic [7:0] stall_cnt;
  logic [1:0] stall_cnt_s;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit m_pend;
  int m_tag;
  int m_stall;
  int m_stall_s;
`ifdef BC_RR_EN
  int m_last;
`endif

  bc_arb_ctrl_if bus_w ();
  bc_arb_ctrl_if bus_n ();

  assign bus_w.dg_req  = dg_req;
  assign bus_w.ps_req  = ps_req;
  assign bus_w.rf_req  = rf_req;
  assign bus_w.dm_req  = dm_req;
  assign bus_w.imm_req = imm_req;
  assign bus_n.dg_req  = dg_req;
  assign bus_n.ps_req  = ps_req;
  assign bus_n.rf_req  = rf_req;
  assign bus_n.dm_req  = dm_req;
  assign bus_n.imm_req = imm_req;

  bc_arb_ctrl #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_w), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  bc_arb_ctrl #(.CNT_W(2)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_n), .stall_clr(stall_clr), .stall_cnt(stall_cnt_s)
  );

  always #5 clk = ~clk;

  function automatic int winner();
    logic [2:0] r;
    int w;
    r = {rf_req, ps_req, dg_req};
    w = -1;
`ifdef BC_RR_EN
    for (int k = 1; k <= 3; k++)
      if (w < 0 && r[(m_last + k) % 3]) w = (m_last + k) % 3;
`else
    for (int k = 0; k < 3; k++)
      if (w < 0 && r[k]) w = k;
`endif
    return w;
  endfunction

  function automatic obs_t expect_now();
    obs_t e;
    int w;
    w = winner();
    e.drr_sclt = (w < 0) ? 2'd3 : 2'(w);
    e.drr_gnt  = (w < 0) ? 3'd0 : 3'(1 << w);
    if (m_pend) begin
      e.di_sclt = 2'd1; e.di_gnt = 2'b00; e.out_vld = 1'b1; e.out_src = 3'(m_tag);
    end else if (dm_req) begin
      e.di_sclt = 2'd0; e.di_gnt = 2'b01; e.out_vld = 1'b0; e.out_src = 3'd4;
    end else if (imm_req) begin
      e.di_sclt = 2'd2; e.di_gnt = 2'b10; e.out_vld = 1'b0; e.out_src = 3'd5;
    end else begin
      e.di_sclt = 2'd3; e.di_gnt = 2'b00; e.out_vld = 1'b0; e.out_src = 3'd0;
    end
    e.stall   = 8'(m_stall);
    e.stall_s = 2'(m_stall_s);
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.drr_sclt = bus_w.bc_drr_sclt;
    o.drr_gnt  = bus_w.drr_gnt;
    o.di_sclt  = bus_w.bc_di_sclt;
    o.di_gnt   = bus_w.di_gnt;
    o.out_vld  = bus_w.out_vld;
    o.out_src  = bus_w.out_src;
    o.stall    = stall_cnt;
    o.stall_s  = stall_cnt_s;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("drr=%b gnt=%b di=%b dgnt=%b vld=%b src=%0d stall=%0d/%0d",
                     o.drr_sclt, o.drr_gnt, o.di_sclt, o.di_gnt, o.out_vld, o.out_src,
                     o.stall, o.stall_s);
  endfunction

  // Advance the model by one clock edge using the currently applied inputs.
  task automatic model_step();
    int w, nreq, ngnt;
    w    = winner();
    nreq = int'(dg_req) + int'(ps_req) + int'(rf_req) + int'(dm_req) + int'(imm_req);
    ngnt = ((w >= 0) ? 1 : 0) + ((!m_pend && (dm_req || imm_req)) ? 1 : 0);
    if (!rst_n) begin
      m_pend = 1'b0; m_tag = 0; m_stall = 0; m_stall_s = 0;
`ifdef BC_RR_EN
      m_last = 2;
`endif
    end else begin
      if (stall_clr) begin
        m_stall = 0; m_stall_s = 0;
      end else if (nreq > ngnt) begin
        if (m_stall < 255) m_stall++;
        if (m_stall_s < 3) m_stall_s++;
      end
      m_pend = (w >= 0);
      if (w >= 0) begin
        m_tag = w + 1;
`ifdef BC_RR_EN
        m_last = w;
`endif
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r, input logic clr, input logic rn);
    {imm_req, dm_req, rf_req, ps_req, dg_req} = r;
    stall_clr = clr;
    rst_n     = rn;
  endtask

  task automatic do_reset();
    drive(5'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(5'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    obs_t o, e;
    drive(5'b0, 1'b0, 1'b0);
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      if (i == 2) drive(5'b0, 1'b0, 1'b1);
      @(negedge clk);
      o = observe(); e = expect_now(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset c%0d: got %s exp %s", i, fmt(o), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_single_ps();
    obs_t o, e;
    do_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      drive((i == 0) ? R_PS : 5'b0, 1'b0, 1'b1);
      @(negedge clk);
      o = observe(); e = expect_now(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL single_ps c%0d: got %s exp %s", i, fmt(o), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [2:0] g;
    do_reset();
    for (int unsigned i = 0; i < 7; i++) begin
      drive((i < 6) ? (R_DG | R_PS | R_RF) : 5'b0, 1'b0, 1'b1);
      @(negedge clk);
      o = observe(); e = expect_now(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back c%0d: got %s exp %s", i, fmt(o), fmt(e));
      end
      if (i < 6) begin
`ifdef BC_RR_EN
        g = 3'b001 << (i % 3);
`else
        g = 3'b001;
`endif
        vectors++;
        if (o.drr_gnt !== g) begin
          miscompares++;
          $display("FAIL back_to_back_gnt c%0d: got %b exp %b", i, o.drr_gnt, g);
        end
      end
      tick();
    end
    vectors++;
    if (stall_cnt !== 8'd6) begin
      miscompares++;
      $display("FAIL back_to_back_stall: got %0d exp 6", stall_cnt);
    end
  endtask

  task automatic test_reg_then_direct();
    obs_t o, e;
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      case (i)
        0: drive(R_RF, 1'b0, 1'b1);
        1, 2: drive(R_DM | R_IMM, 1'b0, 1'b1);
        default: drive(5'b0, 1'b0, 1'b1);
      endcase
      @(negedge clk);
      o = observe(); e = expect_now(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reg_then_direct c%0d: got %s exp %s", i, fmt(o), fmt(e));
      end
      tick();
    end
    vectors++;
    if (stall_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL reg_then_direct_stall: got %0d exp 2", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    obs_t o, e;
    do_reset();
    for (int unsigned i = 0; i < 6; i++) begin
      drive(R_DM | R_IMM, (i == 5) ? 1'b1 : 1'b0, 1'b1);
      @(negedge clk);
      o = observe(); e = expect_now(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL saturation c%0d: got %s exp %s", i, fmt(o), fmt(e));
      end
      if (i == 5) begin
        vectors++;
        if (stall_cnt_s !== 2'd3 || stall_cnt !== 8'd5) begin
          miscompares++;
          $display("FAIL saturation_peak: got %0d/%0d exp 5/3", stall_cnt, stall_cnt_s);
        end
      end
      tick();
    end
    vectors++;
    if (stall_cnt_s !== 2'd0 || stall_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL saturation_clear: got %0d/%0d exp 0/0", stall_cnt, stall_cnt_s);
    end
    drive(5'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_pending();
    obs_t o, e;
    do_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      case (i)
        0: drive(R_DG, 1'b0, 1'b1);
        1: drive(5'b0, 1'b0, 1'b0);
        default: drive(5'b0, 1'b0, 1'b1);
      endcase
      @(negedge clk);
      o = observe(); e = expect_now(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_pending c%0d: got %s exp %s", i, fmt(o), fmt(e));
      end
      if (i == 2) begin
        vectors++;
        if (o.out_vld !== 1'b0 || o.out_src !== 3'd0) begin
          miscompares++;
          $display("FAIL reset_pending_drop: got vld=%b src=%0d exp vld=0 src=0",
                   o.out_vld, o.out_src);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [4:0] r;
    do_reset();
    for (int unsigned i = 0; i < 400; i++) begin
      r = 5'($urandom);
      drive(r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) != 0));
      @(negedge clk);
      o = observe(); e = expect_now(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random c%0d: got %s exp %s", i, fmt(o), fmt(e));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_ps();
    test_back_to_back();
    test_reg_then_direct();
    test_saturation();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
